// File: rtl/polyphase_fir_pkg.sv
// Shared types and constants for the two-phase polyphase FIR controller.
package polyphase_fir_pkg;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_t;

  localparam logic [1:0] COEF_ADDR_H0 = 2'd0;
  localparam logic [1:0] COEF_ADDR_H1 = 2'd1;
  localparam logic [1:0] COEF_ADDR_H2 = 2'd2;

  localparam int DEF_H0 = 1;
  localparam int DEF_H1 = 2;
  localparam int DEF_H2 = 3;

endpackage

// File: rtl/polyfir_coef_bank.sv
// Shadow/active tap registers; shadow writes land immediately, active copies
// only when the sequencer reports a pair boundary.
module polyfir_coef_bank
  import polyphase_fir_pkg::*;
#(
  parameter int H0_INIT = DEF_H0,
  parameter int H1_INIT = DEF_H1,
  parameter int H2_INIT = DEF_H2
) (
  input  logic       clk_2f,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  coef_t      wr_data,
  input  logic       commit,
  input  logic       boundary,
  output coef_t      h0,
  output coef_t      h1,
  output coef_t      h2
);

  coef_t sh0_q, sh1_q, sh2_q;
  coef_t sh0_d, sh1_d, sh2_d;
  coef_t act0_q, act1_q, act2_q;
  logic  pend_q;
  logic  apply;

  // Next shadow includes this cycle's write so a same-cycle commit sees it.
  always_comb begin
    sh0_d = sh0_q;
    sh1_d = sh1_q;
    sh2_d = sh2_q;
    if (wr_en) begin
      case (wr_addr)
        COEF_ADDR_H0: sh0_d = wr_data;
        COEF_ADDR_H1: sh1_d = wr_data;
        COEF_ADDR_H2: sh2_d = wr_data;
        default: ;
      endcase
    end
  end

  assign apply = boundary && (commit || pend_q);

  always_ff @(posedge clk_2f or posedge rst) begin
    if (rst) begin
      sh0_q  <= coef_t'(H0_INIT);
      sh1_q  <= coef_t'(H1_INIT);
      sh2_q  <= coef_t'(H2_INIT);
      act0_q <= coef_t'(H0_INIT);
      act1_q <= coef_t'(H1_INIT);
      act2_q <= coef_t'(H2_INIT);
      pend_q <= 1'b0;
    end else begin
      sh0_q  <= sh0_d;
      sh1_q  <= sh1_d;
      sh2_q  <= sh2_d;
      pend_q <= (commit || pend_q) && !apply;
      if (apply) begin
        act0_q <= sh0_d;
        act1_q <= sh1_d;
        act2_q <= sh2_d;
      end
    end
  end

  assign h0 = act0_q;
  assign h1 = act1_q;
  assign h2 = act2_q;

endmodule

// File: rtl/polyphase_fir_ctrl.sv
// Sample sequencer for the two-phase polyphase FIR: pair-atomic handshake,
// zero flushes and coefficient commit. Optional stall counter: POLYFIR_CTRL_STALL_CNT_EN.
module polyphase_fir_ctrl
  import polyphase_fir_pkg::*;
#(
  parameter int FLUSH_LEN = 6,
  parameter int CNT_W     = 16,
  parameter int H0_INIT   = DEF_H0,
  parameter int H1_INIT   = DEF_H1,
  parameter int H2_INIT   = DEF_H2
) (
  input  logic                    clk_2f,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    flush_req,
  input  logic                    s_valid,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                    s_ready,
  output logic signed [DATA_W-1:0] x_out,
  output logic                    x_valid,
  output logic                    x_phase,
  input  logic                    coef_wr_en,
  input  logic [1:0]              coef_wr_addr,
  input  logic signed [COEF_W-1:0] coef_wr_data,
  input  logic                    coef_commit,
  output logic signed [COEF_W-1:0] h0,
  output logic signed [COEF_W-1:0] h1,
  output logic signed [COEF_W-1:0] h2,
  output logic                    busy,
  output logic                    flush_done,
  output logic [CNT_W-1:0]        sample_cnt
`ifdef POLYFIR_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);

  localparam int FC_W = $clog2(FLUSH_LEN);
  localparam logic [FC_W-1:0] FC_START = FC_W'(FLUSH_LEN - 1);

  ctrl_state_t     state_q, state_d;
  logic            phase_q;
  logic            flush_pend_q;
  logic [FC_W-1:0] fcnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic            accept;
  logic            flush_last;
  logic            boundary;

  sample_t         x_data_p1;
  logic            vld_p1;
  logic            phase_p1;
  logic            done_p1;

  // Leaving RUN is only decided with the phase pointer even, so a pair is never split.
  always_comb begin
    state_d    = state_q;
    s_ready    = 1'b0;
    flush_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        s_ready = 1'b1;
        if (!phase_q) begin
          if (flush_pend_q || flush_req) begin
            s_ready = 1'b0;
            state_d = FLUSH;
          end else if (!enable) begin
            s_ready = 1'b0;
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) begin
          flush_last = 1'b1;
          state_d    = enable ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept   = s_valid && s_ready;
  assign boundary = (state_q == IDLE) || (state_q == RUN && !phase_q && !accept);

  always_ff @(posedge clk_2f or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      fcnt_q       <= FC_START;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        phase_q <= ~phase_q;
        cnt_q   <= cnt_q + 1'b1;
      end
      if (flush_last)
        flush_pend_q <= 1'b0;
      else if (flush_req && state_q == RUN)
        flush_pend_q <= 1'b1;
      if (state_q == FLUSH && !flush_last)
        fcnt_q <= fcnt_q - 1'b1;
      else
        fcnt_q <= FC_START;
    end
  end

  // ---- stage p1: registered sample/zero output toward the splitter ----
  always_ff @(posedge clk_2f or posedge rst) begin
    if (rst) begin
      x_data_p1 <= '0;
      vld_p1    <= 1'b0;
      phase_p1  <= 1'b0;
      done_p1   <= 1'b0;
    end else begin
      vld_p1  <= accept || (state_q == FLUSH);
      done_p1 <= flush_last;
      if (accept) begin
        x_data_p1 <= s_data;
        phase_p1  <= phase_q;
      end else if (state_q == FLUSH) begin
        x_data_p1 <= '0;
        phase_p1  <= ~fcnt_q[0];
      end
    end
  end

`ifdef POLYFIR_CTRL_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk_2f or posedge rst) begin
    if (rst)
      stall_q <= '0;
    else if (flush_last)
      stall_q <= '0;
    else if (state_q == RUN && phase_q && !s_valid && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`endif

  polyfir_coef_bank #(
    .H0_INIT (H0_INIT),
    .H1_INIT (H1_INIT),
    .H2_INIT (H2_INIT)
  ) u_coef_bank (
    .clk_2f   (clk_2f),
    .rst      (rst),
    .wr_en    (coef_wr_en),
    .wr_addr  (coef_wr_addr),
    .wr_data  (coef_wr_data),
    .commit   (coef_commit),
    .boundary (boundary),
    .h0       (h0),
    .h1       (h1),
    .h2       (h2)
  );

  assign x_out      = x_data_p1;
  assign x_valid    = vld_p1;
  assign x_phase    = phase_p1;
  assign flush_done = done_p1;
  assign busy       = (state_q != IDLE);
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_polyphase_fir_ctrl.sv
// Directed bench for polyphase_fir_ctrl: streaming, pair completion, flush, commit, wrap, reset.
`timescale 1ns/1ps
module tb_polyphase_fir_ctrl;

  logic               clk_2f = 1'b0;
  logic               rst;
  logic               enable, flush_req, s_valid;
  logic signed [15:0] s_data;
  logic               s_ready;
  logic signed [15:0] x_out;
  logic               x_valid, x_phase;
  logic               coef_wr_en;
  logic [1:0]         coef_wr_addr;
  logic signed [15:0] coef_wr_data;
  logic               coef_commit;
  logic signed [15:0] h0, h1, h2;
  logic               busy, flush_done;
  logic [15:0]        sample_cnt;
`ifdef POLYFIR_CTRL_STALL_CNT_EN
  logic [15:0]        stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  polyphase_fir_ctrl dut (
    .clk_2f       (clk_2f),
    .rst          (rst),
    .enable       (enable),
    .flush_req    (flush_req),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .x_out        (x_out),
    .x_valid      (x_valid),
    .x_phase      (x_phase),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data),
    .coef_commit  (coef_commit),
    .h0           (h0),
    .h1           (h1),
    .h2           (h2),
    .busy         (busy),
    .flush_done   (flush_done),
    .sample_cnt   (sample_cnt)
`ifdef POLYFIR_CTRL_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk_2f = ~clk_2f;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; flush_req = 1'b0; s_valid = 1'b0; s_data = '0;
    coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0; coef_commit = 1'b0;
    repeat (3) step();
    checks++; if (x_valid !== 1'b0 || x_out !== 16'sd0 || x_phase !== 1'b0) begin
      errors++; $display("FAIL reset_x got v=%b d=%0d p=%b exp 0/0/0", x_valid, x_out, x_phase); end
    checks++; if (s_ready !== 1'b0 || busy !== 1'b0 || flush_done !== 1'b0) begin
      errors++; $display("FAIL reset_ctl got rdy=%b busy=%b done=%b exp 0/0/0", s_ready, busy, flush_done); end
    checks++; if (sample_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got %0d exp 0", sample_cnt); end
    checks++; if (h0 !== 16'sd1 || h1 !== 16'sd2 || h2 !== 16'sd3) begin
      errors++; $display("FAIL reset_coef got %0d/%0d/%0d exp 1/2/3", h0, h1, h2); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_stream();
    logic signed [15:0] vals [4];
    vals = '{16'sd10, 16'sd20, 16'sd30, 16'sd40};
    enable = 1'b1;
    step();
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = vals[i];
      #1;
      checks++; if (s_ready !== 1'b1) begin
        errors++; $display("FAIL stream_ready[%0d] got %b exp 1", i, s_ready); end
      step();
      checks++; if (x_valid !== 1'b1 || x_out !== vals[i] || x_phase !== 1'(i % 2)) begin
        errors++; $display("FAIL stream_out[%0d] got v=%b d=%0d p=%b exp 1/%0d/%0d",
                           i, x_valid, x_out, x_phase, vals[i], i % 2); end
    end
    s_valid = 1'b0;
    checks++; if (sample_cnt !== 16'd4) begin
      errors++; $display("FAIL stream_cnt got %0d exp 4", sample_cnt); end
    step();
    checks++; if (x_valid !== 1'b0 || x_out !== 16'sd40) begin
      errors++; $display("FAIL stream_idle_out got v=%b d=%0d exp 0/40", x_valid, x_out); end
  endtask

  task automatic test_enable_drop();
    s_valid = 1'b1; s_data = 16'sd10;
    step();
    enable = 1'b0; s_valid = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL drop_midpair got rdy=%b busy=%b exp 1/1", s_ready, busy); end
    step();
    checks++; if (x_valid !== 1'b0) begin
      errors++; $display("FAIL drop_starve_valid got %b exp 0", x_valid); end
    s_valid = 1'b1; s_data = 16'sd20;
    step();
    checks++; if (x_valid !== 1'b1 || x_out !== 16'sd20 || x_phase !== 1'b1) begin
      errors++; $display("FAIL drop_odd got v=%b d=%0d p=%b exp 1/20/1", x_valid, x_out, x_phase); end
    s_valid = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b0) begin
      errors++; $display("FAIL drop_boundary_ready got %b exp 0", s_ready); end
    step();
    checks++; if (busy !== 1'b0 || s_ready !== 1'b0 || sample_cnt !== 16'd6) begin
      errors++; $display("FAIL drop_idle got busy=%b rdy=%b cnt=%0d exp 0/0/6", busy, s_ready, sample_cnt); end
  endtask

  task automatic test_flush();
    enable = 1'b1;
    step();
    s_valid = 1'b1; s_data = 16'sd7;
    step();
    flush_req = 1'b1; s_data = 16'sd8;
    #1;
    checks++; if (s_ready !== 1'b1) begin
      errors++; $display("FAIL flush_midpair_ready got %b exp 1", s_ready); end
    step();
    flush_req = 1'b0; s_data = 16'sd9;
    checks++; if (x_out !== 16'sd8 || x_phase !== 1'b1) begin
      errors++; $display("FAIL flush_pair_done got d=%0d p=%b exp 8/1", x_out, x_phase); end
    #1;
    checks++; if (s_ready !== 1'b0) begin
      errors++; $display("FAIL flush_decision_ready got %b exp 0", s_ready); end
    step();
    checks++; if (x_valid !== 1'b0) begin
      errors++; $display("FAIL flush_no_accept got %b exp 0", x_valid); end
    enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      flush_req = (k == 2);
      #1;
      checks++; if (s_ready !== 1'b0) begin
        errors++; $display("FAIL flush_ready[%0d] got %b exp 0", k, s_ready); end
      step();
      checks++; if (x_valid !== 1'b1 || x_out !== 16'sd0 || x_phase !== 1'(k % 2) ||
                    flush_done !== (k == 5)) begin
        errors++; $display("FAIL flush_zero[%0d] got v=%b d=%0d p=%b done=%b exp 1/0/%0d/%0d",
                           k, x_valid, x_out, x_phase, flush_done, k % 2, k == 5); end
    end
    flush_req = 1'b0; s_valid = 1'b0;
    checks++; if (busy !== 1'b0 || sample_cnt !== 16'd8) begin
      errors++; $display("FAIL flush_exit got busy=%b cnt=%0d exp 0/8", busy, sample_cnt); end
    step();
    checks++; if (flush_done !== 1'b0 || x_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_after got done=%b v=%b busy=%b exp 0/0/0", flush_done, x_valid, busy); end
  endtask

  task automatic test_coef();
    enable = 1'b1;
    step();
    s_valid = 1'b1; s_data = 16'sd100;
    coef_wr_en = 1'b1; coef_wr_addr = 2'd1; coef_wr_data = -16'sd5; coef_commit = 1'b1;
    step();
    coef_wr_en = 1'b0; coef_commit = 1'b0; s_data = 16'sd101;
    checks++; if (x_out !== 16'sd100 || h1 !== 16'sd2) begin
      errors++; $display("FAIL coef_even got d=%0d h1=%0d exp 100/2", x_out, h1); end
    step();
    s_valid = 1'b0;
    checks++; if (x_out !== 16'sd101 || x_phase !== 1'b1 || h1 !== 16'sd2) begin
      errors++; $display("FAIL coef_odd got d=%0d p=%b h1=%0d exp 101/1/2", x_out, x_phase, h1); end
    step();
    checks++; if (h0 !== 16'sd1 || h1 !== -16'sd5 || h2 !== 16'sd3) begin
      errors++; $display("FAIL coef_boundary got %0d/%0d/%0d exp 1/-5/3", h0, h1, h2); end
    enable = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL coef_idle got busy=%b exp 0", busy); end
    coef_wr_en = 1'b1; coef_wr_addr = 2'd2; coef_wr_data = 16'sd32767; coef_commit = 1'b1;
    step();
    checks++; if (h2 !== 16'sd32767) begin
      errors++; $display("FAIL coef_idle_commit got %0d exp 32767", h2); end
    coef_wr_addr = 2'd3; coef_wr_data = 16'sd99;
    step();
    checks++; if (h0 !== 16'sd1 || h1 !== -16'sd5 || h2 !== 16'sd32767) begin
      errors++; $display("FAIL coef_addr3 got %0d/%0d/%0d exp 1/-5/32767", h0, h1, h2); end
    coef_wr_addr = 2'd0; coef_wr_data = -16'sd32768; coef_commit = 1'b0;
    step();
    checks++; if (h0 !== 16'sd1) begin
      errors++; $display("FAIL coef_shadow_only got %0d exp 1", h0); end
    coef_wr_en = 1'b0; coef_commit = 1'b1;
    step();
    coef_commit = 1'b0;
    checks++; if (h0 !== -16'sd32768) begin
      errors++; $display("FAIL coef_late_commit got %0d exp -32768", h0); end
  endtask

  task automatic test_wrap();
    enable = 1'b1;
    step();
    s_valid = 1'b1; s_data = 16'sd1;
    repeat (16'hFFFF - 10) step();
    s_valid = 1'b0;
    checks++; if (sample_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_max got %0h exp ffff", sample_cnt); end
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    checks++; if (sample_cnt !== 16'h0000) begin
      errors++; $display("FAIL wrap_zero got %0h exp 0", sample_cnt); end
  endtask

  task automatic test_reset_in_flush();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    step();
    checks++; if (x_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL rflush_active got v=%b busy=%b exp 1/1", x_valid, busy); end
    step();
    rst = 1'b1;
    step();
    checks++; if (x_valid !== 1'b0 || x_out !== 16'sd0 || x_phase !== 1'b0 || s_ready !== 1'b0 ||
                  busy !== 1'b0 || flush_done !== 1'b0 || sample_cnt !== 16'd0) begin
      errors++; $display("FAIL rflush_outs got v=%b d=%0d p=%b rdy=%b busy=%b done=%b cnt=%0d exp all 0",
                         x_valid, x_out, x_phase, s_ready, busy, flush_done, sample_cnt); end
    checks++; if (h0 !== 16'sd1 || h1 !== 16'sd2 || h2 !== 16'sd3) begin
      errors++; $display("FAIL rflush_coef got %0d/%0d/%0d exp 1/2/3", h0, h1, h2); end
    enable = 1'b0;
    rst = 1'b0;
    step();
    checks++; if (busy !== 1'b0 || x_valid !== 1'b0) begin
      errors++; $display("FAIL rflush_release got busy=%b v=%b exp 0/0", busy, x_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_enable_drop();
    test_flush();
    test_coef();
    test_wrap();
    test_reset_in_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
